sample_fetch_master: RTL and testbench

SAMPLE_FETCH_MASTER -- requirements
Module: sample_fetch_master

---
 rtl/sample_fetch_master_pkg.sv | 19 +
 rtl/sample_fifo.sv | 60 ++++++
 rtl/sample_fetch_master.sv | 135 +++++++++++++
 tb/tb_sample_fetch_master.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_fetch_master_pkg.sv
// Shared definitions for the sample fetch master.
// Holds the FSM state type, the default Avalon-MM word-address width and
// output FIFO depth, and the fixed 32-bit sample data width.
`timescale 1ns/1ps
package sample_fetch_master_pkg;

  localparam int unsigned DEFAULT_ADDR_W     = 9;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
  localparam int unsigned DATA_W             = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_ABORT,
    ST_DONE
  } fetch_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO for fetched samples.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   flush           - empties the FIFO on the next edge (wins over push/pop)
//   push, push_data - write request and data (ignored when full)
//   pop             - read request (ignored when empty)
//   head_data       - current head word, valid whenever count != 0
//   count           - number of stored words (0..DEPTH)
`timescale 1ns/1ps
module sample_fifo
  import sample_fetch_master_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !reset && !flush && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)
        count <= count + CNT_W'(1);
      else if (!do_push && do_pop)
        count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/sample_fetch_master.sv
// Avalon-MM read master that fetches a burst of consecutive words into an
// output FIFO with a valid/ready consumer interface.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start, base_addr,
//   num_words           - burst request (sampled only when idle)
//   abort               - early termination request
//   busy, done          - burst in progress / one-cycle normal completion
//   avm_*               - Avalon-MM master (one read outstanding at most)
//   out_data, out_valid,
//   out_ready           - FIFO head, non-empty flag, consumer accept
`timescale 1ns/1ps
module sample_fetch_master
  import sample_fetch_master_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned REM_W = ADDR_W + 1;

  fetch_state_t      state;
  logic [ADDR_W-1:0] addr_q;
  logic [REM_W-1:0]  remain_q;
  logic              abort_pend;  // abort seen while a read was stalled
  logic              resp_pend;   // ABORT still owes a word to discard

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;

  assign fifo_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
  // No push happens in REQ, so full can only clear there: once raised,
  // avm_read stays high until the handshake moves the FSM on.
  assign avm_read    = (state == ST_REQ) && !fifo_full;
  assign avm_address = addr_q;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign out_valid   = (fifo_count != '0);
  assign fifo_pop    = out_valid && out_ready;
  assign fifo_push   = (state == ST_RESP) && avm_readdatavalid && !abort;
  assign fifo_flush  = (state == ST_ABORT) ||
                       ((state == ST_REQ) && abort && !avm_read);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      abort_pend <= 1'b0;
      resp_pend  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q   <= base_addr;
            remain_q <= num_words;
            state    <= (num_words == '0) ? ST_DONE : ST_REQ;
          end
        end
        ST_REQ: begin
          if (avm_read) begin
            if (!avm_waitrequest) begin
              if (abort || abort_pend) begin
                state      <= ST_ABORT;
                resp_pend  <= 1'b1;
                abort_pend <= 1'b0;
              end else begin
                state <= ST_RESP;
              end
            end else if (abort) begin
              abort_pend <= 1'b1;
            end
          end else if (abort) begin
            state <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (abort) begin
            // A word arriving together with abort is simply dropped.
            state     <= ST_ABORT;
            resp_pend <= !avm_readdatavalid;
          end else if (avm_readdatavalid) begin
            addr_q   <= addr_q + ADDR_W'(1);
            remain_q <= remain_q - REM_W'(1);
            state    <= (remain_q == REM_W'(1)) ? ST_DONE : ST_REQ;
          end
        end
        ST_ABORT: begin
          if (!resp_pend || avm_readdatavalid) begin
            state     <= ST_IDLE;
            resp_pend <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (avm_readdata),
    .pop       (fifo_pop),
    .head_data (out_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sample_fetch_master.sv
// Scoreboard bench for sample_fetch_master: a simple Avalon-MM slave with
// configurable wait states and read latency, a reference model that expands
// each burst into its expected address and data sequences, and a monitor
// that compares every read handshake and every consumed word.
`timescale 1ns/1ps
module tb_sample_fetch_master;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset, start, abort, out_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          busy, done, avm_read, avm_waitrequest, avm_readdatavalid;
  logic [AW-1:0] avm_address;
  logic [31:0]   avm_readdata, out_data;
  logic          out_valid;

  sample_fetch_master #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .abort(abort), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  localparam logic [63:0] NONE = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return ({23'd0, a} * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
  endfunction

  // Reference model state
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  int unsigned   exp_done = 0;

  // Slave / consumer configuration
  int unsigned waits_cfg = 0;
  int unsigned lat_cfg   = 1;
  int unsigned ready_mode = 1;   // 0 low, 1 high, 2 random
  bit          force_rdv = 0;

  // Slave state
  int unsigned   cyc = 0;
  int unsigned   wcnt = 0;
  logic [AW-1:0] pend_addr[$];
  int unsigned   pend_due[$];
  bit            hs_last = 0;
  logic [AW-1:0] hs_addr = '0;

  initial begin
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (hs_last) begin
        pend_addr.push_back(hs_addr);
        pend_due.push_back(cyc - 1 + lat_cfg);
      end
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
      if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (force_rdv) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'hDEAD_BEEF;
      end
      if (avm_read && wcnt < waits_cfg) begin
        avm_waitrequest = 1'b1;
        wcnt++;
      end else begin
        avm_waitrequest = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  bit            prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;
  int unsigned   hs_cnt = 0;
  int unsigned   done_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
      hs_last = 0;
    end else begin
      if (prev_stall) begin
        check("read_held", avm_read, 1);
        check("addr_held", avm_address, prev_addr);
      end
      if (avm_read)
        check("one_outstanding", pend_addr.size() + int'(avm_readdatavalid && !force_rdv), 0);
      hs_last = avm_read && !avm_waitrequest;
      hs_addr = avm_address;
      if (hs_last) begin
        hs_cnt++;
        check("read_addr", avm_address,
              exp_addr_q.size() != 0 ? 64'(exp_addr_q.pop_front()) : NONE);
      end
      if (out_valid && out_ready)
        check("out_data", out_data,
              exp_data_q.size() != 0 ? 64'(exp_data_q.pop_front()) : NONE);
      if (done) done_cnt++;
      prev_stall = avm_read && avm_waitrequest;
      prev_addr = avm_address;
    end
  end

  task automatic start_burst(input int unsigned b, input int unsigned n, input bit exp_dn);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = AW'(b);
    num_words = (AW+1)'(n);
    for (int unsigned i = 0; i < n; i++) begin
      exp_addr_q.push_back(AW'(b + i));
      exp_data_q.push_back(mem_word(AW'(b + i)));
    end
    if (exp_dn) exp_done++;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    num_words = (AW+1)'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    while ((busy || exp_data_q.size() != 0 || exp_addr_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_drained"}, exp_data_q.size() + exp_addr_q.size(), 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_done_count"}, done_cnt, exp_done);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned h0;
    int unsigned n;
    bit seen_valid;

    reset = 1'b1; start = 1'b1; abort = 1'b0;
    base_addr = 9'h055; num_words = 10'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read", avm_read, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_address", avm_address, 0);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;

    // Basic burst with cycle-exact latency and throughput
    h0 = hs_cnt;
    start_burst(9'h010, 4, 1);
    @(negedge clk);
    check("t1_read_cycle1", avm_read, 1);
    check("t1_addr_cycle1", avm_address, 9'h010);
    @(negedge clk);
    check("t1_valid_cycle2", out_valid, 0);
    @(negedge clk);
    check("t1_valid_cycle3", out_valid, 1);
    repeat (3) @(negedge clk);
    check("t1_reads_by_cycle6", hs_cnt - h0, 3);
    repeat (2) @(negedge clk);
    check("t1_reads_by_cycle8", hs_cnt - h0, 4);
    check("t1_done_cycle8", done, 0);
    @(negedge clk);
    check("t1_done_cycle9", done, 1);
    wait_idle("t1");

    // Zero-length burst
    h0 = hs_cnt;
    seen_valid = 0;
    start_burst(9'h005, 0, 1);
    repeat (4) begin
      @(negedge clk);
      seen_valid |= out_valid;
    end
    check("t2_no_reads", hs_cnt - h0, 0);
    check("t2_no_valid", seen_valid, 0);
    wait_idle("t2");

    // Address wrap
    start_burst(9'h1FE, 3, 1);
    wait_idle("t3");

    // Stalls, full FIFO, ignored start
    waits_cfg = 3; ready_mode = 0;
    h0 = hs_cnt;
    start_burst(9'h040, 6, 1);
    n = 0;
    while (hs_cnt - h0 < 4 && n < 200) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    check("t4_reads_paused", hs_cnt - h0, 4);
    check("t4_full_valid", out_valid, 1);
    check("t4_read_low", avm_read, 0);
    check("t4_busy", busy, 1);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 9'h100; num_words = 10'd2;
    @(posedge clk); #1;
    start = 1'b0;
    ready_mode = 1;
    wait_idle("t4");
    check("t4_total_reads", hs_cnt - h0, 6);

    // Abort during a waitrequest stall
    waits_cfg = 3; ready_mode = 0;
    h0 = hs_cnt;
    start_burst(9'h080, 6, 0);
    n = 0;
    while (hs_cnt - h0 < 2 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(avm_read && avm_waitrequest) && n < 200);
    @(posedge clk); #1;
    abort = 1'b1;
    while (exp_addr_q.size() > 1) void'(exp_addr_q.pop_back());
    exp_data_q.delete();
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle("t5");
    repeat (5) @(negedge clk);
    check("t5_fifo_empty", out_valid, 0);
    check("t5_reads", hs_cnt - h0, 3);
    waits_cfg = 0; ready_mode = 1;
    start_burst(9'h020, 2, 1);
    wait_idle("t5_restart");

    // Abort while waiting on a full FIFO
    ready_mode = 0;
    h0 = hs_cnt;
    start_burst(9'h030, 6, 0);
    n = 0;
    while (hs_cnt - h0 < 4 && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check("t6_read_low", avm_read, 0);
    @(posedge clk); #1;
    abort = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("t6_idle_next", busy, 0);
    check("t6_flushed", out_valid, 0);
    ready_mode = 1;
    wait_idle("t6");

    // Randomised bursts
    ready_mode = 2;
    for (int k = 0; k < 10; k++) begin
      waits_cfg = $urandom_range(0, 2);
      lat_cfg = $urandom_range(1, 3);
      start_burst($urandom_range(0, 511), $urandom_range(1, 10), 1);
      wait_idle("t7");
    end

    // Reset mid-burst with a response in flight, then a stray response
    waits_cfg = 0; lat_cfg = 1; ready_mode = 1;
    start_burst(9'h060, 5, 0);
    n = 0;
    h0 = 0;
    while (h0 < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (avm_read && !avm_waitrequest) h0++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    force_rdv = 1'b1;
    @(negedge clk);
    check("t8_busy", busy, 0);
    check("t8_done", done, 0);
    check("t8_read", avm_read, 0);
    check("t8_out_valid", out_valid, 0);
    check("t8_address", avm_address, 0);
    @(posedge clk); #1;
    force_rdv = 1'b0;
    @(negedge clk);
    check("t8_stray_ignored", out_valid, 0);
    wait_idle("t8");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
